select_arbiter: RTL and testbench
=================================

# select_arbiter

Round-robin arbiter that shares the 4-way one-hot select resource among four requesters. Grants ownership to one requester at a time, drives a 2-bit select index and the matching one-hot select, and holds the grant until the owner releases it or a tenure limit expires. Sits directly upstream of the 2-to-4 select decode, replacing free-running address drive with arbitrated, fair access.

## Interface
- `WIDTH`, 2, select index width; fixed at 2, i.e. 4 requesters.
- `MAX_HOLD`, 16, maximum consecutive grant cycles per tenure, legal range 1..255. Used only when `ARB_TIMEOUT_EN` is defined.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  4  `req[i]` high = requester i wants the resource; level, held until done.
- `done`  in  4  `done[i]` one-cycle pulse = requester i releases its grant.
- `grant_valid`  out  1  a requester currently owns the resource.
- `grant_idx`  out  WIDTH  owner index; 0 when `grant_valid` is low.
- `grant_onehot`  out  [0:3]  `grant_onehot[grant_idx]` = 1 when valid (idx 0 -> 4'b1000, idx 3 -> 4'b0001); 4'b0000 when not valid.
- `preempt`  out  1  one-cycle pulse: tenure limit forced a release.

## Operation
- FSM states:
  - IDLE: no owner.
  - GRANT: owner = `grant_idx`.
- IDLE:
  - If `req` != 0, choose the first requester with `req` set, searching from `last_idx+1` upward mod 4.
  - Register it as owner, set `last_idx` to it, go to GRANT.
  - If `req` == 0, stay in IDLE.
- GRANT, release conditions (any one):
  - `done[owner]` = 1,
  - `req[owner]` = 0,
  - tenure count == `MAX_HOLD` (timeout build only).
- On release, go to IDLE. `grant_valid` is low for exactly one cycle before the next grant (fixed bubble, so the decode output is guaranteed clean between owners).
- `done` and `req` changes from non-owners are ignored while in GRANT.
- Tenure counter: 8 bits. Loads 1 on the IDLE->GRANT edge and increments each GRANT cycle. Release by timeout occurs at the edge where count == `MAX_HOLD` and no voluntary release is present.
- `preempt` is high in the cycle after that edge. A voluntary release in the same cycle takes priority, so `preempt` stays 0.
- Fairness: the previous owner has the lowest priority in the next arbitration, so any continuously requesting requester is granted within 3 tenures.
- `last_idx` resets to 3, so requester 0 has the highest priority out of reset.

## Timing
- All outputs are registered.
- Reset values: `grant_valid`=0, `grant_idx`=0, `grant_onehot`=4'b0000, `preempt`=0, state IDLE, `last_idx`=3, counter 0.
- Latency, request to grant: `req` sampled high at edge N in IDLE -> outputs valid after edge N, i.e. 1 cycle.
- Latency, release to idle: `done` or `req` drop sampled at edge N -> `grant_valid` low after edge N.
- Earliest regrant is after edge N+1.
- Reset asserted mid-grant: outputs reach their reset values after the next edge, regardless of `req`/`done`. `last_idx` returns to 3, and the in-flight tenure is abandoned without a `preempt` pulse.
- Reset has priority over every other event in the same cycle.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - Tenure counter and `MAX_HOLD` limit are active.
  - `preempt` pulses on forced release.
- `ARB_TIMEOUT_EN` undefined:
  - No counter is built.
  - Owner holds until `done[owner]` or `req[owner]` drops.
  - `preempt` is tied 0.

## Test plan
- Reset, then `req`=4'b1111 -> after 1 cycle: `grant_idx`=0, `grant_onehot`=4'b1000. After each `done` pulse, grant order is 1, 2, 3, 0, with one idle cycle between owners.
- `req`=4'b0100 only, `done[2]` pulsed 5 cycles after grant -> `grant_valid` high for 5 cycles, then low. `grant_onehot` was 4'b0010 throughout the grant.
- Owner 1 granted, `done[0]` and `done[3]` pulsed and `req[2]` toggled -> grant to 1 unchanged. Owner 1 drops `req[1]` -> `grant_valid` low on the next cycle.
- `ARB_TIMEOUT_EN`, `MAX_HOLD`=4, `req[3]` held high with no `done` -> `grant_valid` high for exactly 4 cycles, then `preempt`=1 for 1 cycle. With `req`=4'b1001, the next grant is idx 0.
- Reset asserted during GRANT of idx 2 -> next cycle all outputs 0. After reset is released with `req`=4'b1111, grant goes to idx 0.
- `ARB_TIMEOUT_EN` with `done[owner]` coinciding with count == `MAX_HOLD` -> release occurs, `preempt` stays 0.

Source files
------------

// File: rtl/select_arbiter.sv
// select_arbiter
// Round-robin arbiter for the shared 4-way one-hot select resource. One
// requester owns the resource at a time. The owner keeps it until it pulses
// its done bit or drops its req bit. A fixed one-cycle idle bubble separates
// consecutive owners, so the downstream decode is always clean between them.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   defined   - an 8-bit tenure counter forces a release after MAX_HOLD
//               grant cycles, and preempt pulses for that forced release.
//   undefined - no counter is built and preempt is tied to 0.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   req[3:0]      level request per requester, held until done
//   done[3:0]     one-cycle release pulse per requester
//   grant_valid   a requester currently owns the resource
//   grant_idx     owner index (0 when not valid)
//   grant_onehot  [0:3]; bit grant_idx set when valid (idx 0 -> 4'b1000)
//   preempt       one-cycle pulse after a tenure-limit release
module select_arbiter #(
   parameter int WIDTH    = 2,
   parameter int MAX_HOLD = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       req,
   input  logic [3:0]       done,
   output logic             grant_valid,
   output logic [WIDTH-1:0] grant_idx,
   output logic [0:3]       grant_onehot,
   output logic             preempt
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t           state_reg, state_next;
   logic             valid_reg, valid_next;
   logic [WIDTH-1:0] idx_reg, idx_next;
   logic [WIDTH-1:0] last_reg, last_next;
   logic [0:3]       onehot_reg, onehot_next;

   logic [WIDTH-1:0] pick;
   logic [WIDTH-1:0] cand;
   logic             pick_found;
   logic             release_vol;
   logic             timeout;

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

   logic [7:0] count_reg, count_next;
   logic       preempt_reg, preempt_next;

   assign timeout = (state_reg == GRANT) && (count_reg == HOLD_LIMIT);
   assign preempt = preempt_reg;
`else
   assign timeout = 1'b0;
   assign preempt = 1'b0;
`endif

   // Round-robin search: start just after the previous owner, so the previous
   // owner is always considered last.
   always_comb begin
      pick       = '0;
      cand       = '0;
      pick_found = 1'b0;
      for (int off = 1; off <= 4; off++) begin
         cand = last_reg + off[WIDTH-1:0];
         if (!pick_found && req[cand]) begin
            pick       = cand;
            pick_found = 1'b1;
         end
      end
   end

   // Only the owner's done/req bits matter while granted.
   assign release_vol = done[idx_reg] | ~req[idx_reg];

   always_comb begin
      state_next   = state_reg;
      valid_next   = valid_reg;
      idx_next     = idx_reg;
      last_next    = last_reg;
`ifdef ARB_TIMEOUT_EN
      count_next   = count_reg;
      preempt_next = 1'b0;
`endif
      case (state_reg)
         IDLE: begin
            if (pick_found) begin
               state_next = GRANT;
               valid_next = 1'b1;
               idx_next   = pick;
               last_next  = pick;
`ifdef ARB_TIMEOUT_EN
               count_next = 8'd1;
`endif
            end else begin
               valid_next = 1'b0;
               idx_next   = '0;
            end
         end
         GRANT: begin
            if (release_vol || timeout) begin
               // Always pass through IDLE: this is the one-cycle bubble.
               state_next = IDLE;
               valid_next = 1'b0;
               idx_next   = '0;
`ifdef ARB_TIMEOUT_EN
               // A voluntary release in the same cycle wins over the timeout.
               preempt_next = ~release_vol;
`endif
            end else begin
`ifdef ARB_TIMEOUT_EN
               count_next = count_reg + 8'd1;
`endif
            end
         end
         default: begin
            state_next = IDLE;
            valid_next = 1'b0;
            idx_next   = '0;
         end
      endcase
   end

   // Decode the registered one-hot from the next owner so it lines up with
   // grant_idx in the same cycle.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_onehot
         assign onehot_next[gi] = valid_next && (idx_next == WIDTH'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= IDLE;
         valid_reg  <= 1'b0;
         idx_reg    <= '0;
         last_reg   <= '1;
         onehot_reg <= '0;
      end else begin
         state_reg  <= state_next;
         valid_reg  <= valid_next;
         idx_reg    <= idx_next;
         last_reg   <= last_next;
         onehot_reg <= onehot_next;
      end
   end

`ifdef ARB_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg   <= 8'd0;
         preempt_reg <= 1'b0;
      end else begin
         count_reg   <= count_next;
         preempt_reg <= preempt_next;
      end
   end
`endif

   assign grant_valid  = valid_reg;
   assign grant_idx    = idx_reg;
   assign grant_onehot = onehot_reg;

endmodule

// File: tb/tb_select_arbiter.sv
// Testbench for select_arbiter: per-cycle vector table with a scoreboard
// queue, plus a hand-written long-hold sequence. Runs in both builds of
// ARB_TIMEOUT_EN (MAX_HOLD = 4).
module tb_select_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req;
   logic [3:0] done;
   logic       grant_valid;
   logic [1:0] grant_idx;
   logic [0:3] grant_onehot;
   logic       preempt;

`ifdef ARB_TIMEOUT_EN
   localparam bit TMO = 1'b1;
`else
   localparam bit TMO = 1'b0;
`endif

   select_arbiter #(.WIDTH(2), .MAX_HOLD(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .done         (done),
      .grant_valid  (grant_valid),
      .grant_idx    (grant_idx),
      .grant_onehot (grant_onehot),
      .preempt      (preempt)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         rst;
      logic [3:0] req;
      logic [3:0] done;
      bit         ev;
      logic [1:0] eidx;
      bit         ep;
   } vec_t;

   typedef struct {
      bit         ev;
      logic [1:0] eidx;
      logic [3:0] eoh;
      bit         ep;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   task automatic add(input bit r, input logic [3:0] rq, input logic [3:0] dn,
                      input bit ev, input logic [1:0] ei, input bit ep);
      vec_t v;
      v.rst = r; v.req = rq; v.done = dn; v.ev = ev; v.eidx = ei; v.ep = ep;
      vecs.push_back(v);
   endtask

   // Index 0 maps to the leftmost bit of the [0:3] vector.
   function automatic logic [3:0] oh_of(input bit v, input logic [1:0] i);
      logic [3:0] base;
      base = 4'b1000;
      return v ? (base >> i) : 4'b0000;
   endfunction

   initial begin
      exp_t e;
      logic [3:0] act_oh;
      int hold, pseen, dropped, exp_hold;

      // --- reset, then 4'b1111 round-robin 0,1,2,3,0 with bubbles ---
      add(1, 4'b0000, 4'b0000, 0, 0, 0);
      add(0, 4'b1111, 4'b0000, 1, 0, 0);
      add(0, 4'b1111, 4'b0001, 0, 0, 0);
      add(0, 4'b1111, 4'b0000, 1, 1, 0);
      add(0, 4'b1111, 4'b0010, 0, 0, 0);
      add(0, 4'b1111, 4'b0000, 1, 2, 0);
      add(0, 4'b1111, 4'b0100, 0, 0, 0);
      add(0, 4'b1111, 4'b0000, 1, 3, 0);
      add(0, 4'b1111, 4'b1000, 0, 0, 0);
      add(0, 4'b1111, 4'b0000, 1, 0, 0);
      add(0, 4'b1111, 4'b0001, 0, 0, 0);
      // --- lone requester 2; done after the tenure ---
      add(0, 4'b0000, 4'b0000, 0, 0, 0);
      add(0, 4'b0100, 4'b0000, 1, 2, 0);
      add(0, 4'b0100, 4'b0000, 1, 2, 0);
      add(0, 4'b0100, 4'b0000, 1, 2, 0);
      add(0, 4'b0100, 4'b0000, 1, 2, 0);
      if (!TMO) add(0, 4'b0100, 4'b0000, 1, 2, 0);
      // timeout build: done lands exactly at count == MAX_HOLD -> no preempt
      add(0, 4'b0100, 4'b0100, 0, 0, 0);
      add(0, 4'b0000, 4'b0000, 0, 0, 0);
      // --- owner 1 ignores non-owner done/req, then drops req ---
      add(0, 4'b0010, 4'b0000, 1, 1, 0);
      add(0, 4'b0110, 4'b1001, 1, 1, 0);
      add(0, 4'b0010, 4'b0000, 1, 1, 0);
      add(0, 4'b0110, 4'b0000, 1, 1, 0);
      add(0, 4'b0100, 4'b0000, 0, 0, 0);
      add(0, 4'b0100, 4'b0000, 1, 2, 0);
      // --- reset during grant of idx 2 ---
      add(1, 4'b1111, 4'b0000, 0, 0, 0);
      add(0, 4'b1111, 4'b0000, 1, 0, 0);
      add(0, 4'b1111, 4'b0001, 0, 0, 0);
      add(0, 4'b0000, 4'b0000, 0, 0, 0);
      // --- timeout: req[3] held, forced release, then 4'b1001 -> idx 0 ---
      if (TMO) begin
         add(0, 4'b1000, 4'b0000, 1, 3, 0);
         add(0, 4'b1000, 4'b0000, 1, 3, 0);
         add(0, 4'b1000, 4'b0000, 1, 3, 0);
         add(0, 4'b1000, 4'b0000, 1, 3, 0);
         add(0, 4'b1000, 4'b0000, 0, 0, 1);
         add(0, 4'b1001, 4'b0000, 1, 0, 0);
         add(0, 4'b1001, 4'b0001, 0, 0, 0);
         add(0, 4'b0000, 4'b0000, 0, 0, 0);
      end

      reset = 1'b1; req = '0; done = '0;
      @(posedge clk); #1;

      for (int i = 0; i < vecs.size(); i++) begin
         reset = vecs[i].rst;
         req   = vecs[i].req;
         done  = vecs[i].done;
         e.ev = vecs[i].ev; e.eidx = vecs[i].eidx; e.ep = vecs[i].ep;
         e.eoh = oh_of(vecs[i].ev, vecs[i].eidx);
         sb.push_back(e);
         @(posedge clk); #1;
         e = sb.pop_front();
         act_oh = grant_onehot;
         n_vec++;
         if (grant_valid !== e.ev || grant_idx !== e.eidx ||
             act_oh !== e.eoh || preempt !== e.ep) begin
            n_fail++;
            $display("FAIL vec%0d: got valid=%b idx=%0d onehot=%b preempt=%b, want valid=%b idx=%0d onehot=%b preempt=%b",
                     i, grant_valid, grant_idx, act_oh, preempt, e.ev, e.eidx, e.eoh, e.ep);
         end else begin
            $display("vec%0d req=%b done=%b rst=%b -> valid=%b idx=%0d onehot=%b preempt=%b",
                     i, req, done, reset, grant_valid, grant_idx, act_oh, preempt);
         end
      end

      // Hand-written: req[3] held with no done. The timeout build releases
      // after 4 cycles with one preempt pulse; the plain build never lets go
      // within the 40-cycle budget.
      reset = 1'b0; req = 4'b1000; done = 4'b0000;
      hold = 0; pseen = 0; dropped = 0;
      exp_hold = TMO ? 4 : 40;
      for (int c = 0; c < 40 && dropped == 0; c++) begin
         @(posedge clk); #1;
         if (grant_valid && grant_idx == 2'd3) hold++;
         else if (hold > 0) dropped = 1;
         if (preempt) pseen++;
      end
      n_vec++;
      if (hold != exp_hold) begin
         n_fail++;
         $display("FAIL long_hold: got %0d grant cycles, want %0d", hold, exp_hold);
      end else begin
         $display("long_hold: %0d grant cycles", hold);
      end
      n_vec++;
      if (pseen != (TMO ? 1 : 0)) begin
         n_fail++;
         $display("FAIL long_hold_preempt: got %0d pulses, want %0d", pseen, TMO ? 1 : 0);
      end else begin
         $display("long_hold_preempt: %0d pulses", pseen);
      end

      req = 4'b0000;
      @(posedge clk); #1;
      @(posedge clk); #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
